// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: access-size encodings,
// controller state encoding and the word-alignment helper.
package mips_mem_pkg;

    localparam int LSU_ADDR_W = 32;
    localparam int LSU_DATA_W = 32;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RDW,
        S_WR,
        S_ERR,
        S_DONE
    } lsu_state_t;

    // Clears the byte offset so the memory always sees a whole-word address.
    function automatic logic [LSU_ADDR_W-1:0] word_align(input logic [LSU_ADDR_W-1:0] addr);
        return addr & ~LSU_ADDR_W'(3);
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response and memory-bus bundle around the load/store unit.
// The master side is the CPU datapath together with the data memory;
// the slave side is the load/store unit itself.
interface load_store_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_error;

    logic [ADDR_W-1:0] mem_address;
    logic              mem_write;
    logic [DATA_W-1:0] mem_write_data;
    logic [DATA_W-1:0] mem_read_data;

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output mem_read_data,
        input  req_ready, resp_valid, resp_rdata, resp_error,
        input  mem_address, mem_write, mem_write_data
    );

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  mem_read_data,
        output req_ready, resp_valid, resp_rdata, resp_error,
        output mem_address, mem_write, mem_write_data
    );

endinterface

// File: rtl/load_store_unit_align.sv
// Byte-lane steering for the load/store unit: extracts and extends the
// addressed lane of a read word, merges store data into a read word for
// read-modify-write, and flags accesses that straddle their natural boundary.
module lsu_align
    import mips_mem_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_signed,
    input  logic [31:0] read_word,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] merged_word,
    output logic        misaligned
);

    logic [4:0]  shift;
    logic [15:0] lane;
    logic [31:0] lane_mask;

    // Lane position is a shift of the word; big-endian counts lanes from the top.
    always_comb begin
        shift       = '0;
        lane        = '0;
        lane_mask   = '0;
        load_data   = read_word;
        merged_word = store_data;
        misaligned  = 1'b0;
        case (size)
            SZ_BYTE: begin
                shift       = BIG_ENDIAN ? {~offset, 3'b000} : {offset, 3'b000};
                lane        = 16'(read_word >> shift);
                load_data   = {{24{is_signed & lane[7]}}, lane[7:0]};
                lane_mask   = 32'h0000_00FF << shift;
                merged_word = (read_word & ~lane_mask) | ({24'h0, store_data[7:0]} << shift);
            end
            SZ_HALF: begin
                shift       = BIG_ENDIAN ? {~offset[1], 4'b0000} : {offset[1], 4'b0000};
                lane        = 16'(read_word >> shift);
                load_data   = {{16{is_signed & lane[15]}}, lane};
                lane_mask   = 32'h0000_FFFF << shift;
                merged_word = (read_word & ~lane_mask) | ({16'h0, store_data[15:0]} << shift);
                misaligned  = offset[0];
            end
            SZ_WORD: begin
                misaligned = (offset != 2'b00);
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the CPU datapath and a word-addressed data memory.
// One request at a time; sub-word stores become read-modify-write sequences.
// All outputs are registered and follow the controller state.
module load_store_unit
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input logic clk,
    input logic reset,
    load_store_unit_if.slave bus
);

    lsu_state_t        state;
    logic              lat_write;
    logic [1:0]        lat_size;
    logic              lat_signed;
    logic [1:0]        lat_offset;
    logic [DATA_W-1:0] lat_wdata;

    logic [1:0]        align_offset;
    logic [1:0]        align_size;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] merged_word;
    logic              misaligned;
    logic              accept_error;

    // While idle the lane logic judges the incoming request; afterwards the latched one.
    always_comb begin
        align_offset = lat_offset;
        align_size   = lat_size;
        if (state == S_IDLE) begin
            align_offset = bus.req_addr[1:0];
            align_size   = bus.req_size;
        end
    end

    lsu_align #(
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_align (
        .offset      (align_offset),
        .size        (align_size),
        .is_signed   (lat_signed),
        .read_word   (bus.mem_read_data),
        .store_data  (lat_wdata),
        .load_data   (load_data),
        .merged_word (merged_word),
        .misaligned  (misaligned)
    );

    assign accept_error = misaligned || (bus.req_size == SZ_RSVD);

    // Controller: each transition also loads the outputs for the state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= S_IDLE;
            lat_write          <= 1'b0;
            lat_size           <= SZ_BYTE;
            lat_signed         <= 1'b0;
            lat_offset         <= '0;
            lat_wdata          <= '0;
            bus.req_ready      <= 1'b1;
            bus.resp_valid     <= 1'b0;
            bus.resp_rdata     <= '0;
            bus.resp_error     <= 1'b0;
            bus.mem_address    <= '0;
            bus.mem_write      <= 1'b0;
            bus.mem_write_data <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        lat_write      <= bus.req_write;
                        lat_size       <= bus.req_size;
                        lat_signed     <= bus.req_signed;
                        lat_offset     <= bus.req_addr[1:0];
                        lat_wdata      <= bus.req_wdata;
                        bus.req_ready  <= 1'b0;
                        bus.resp_rdata <= '0;
                        if (accept_error) begin
                            state          <= S_ERR;
                            bus.resp_valid <= 1'b1;
                            bus.resp_error <= 1'b1;
                        end else if (bus.req_write && (bus.req_size == SZ_WORD)) begin
                            state              <= S_WR;
                            bus.mem_address    <= word_align(bus.req_addr);
                            bus.mem_write      <= 1'b1;
                            bus.mem_write_data <= bus.req_wdata;
                        end else begin
                            state           <= S_RD;
                            bus.mem_address <= word_align(bus.req_addr);
                        end
                    end
                end
                S_RD: begin
                    state <= S_RDW;
                end
                S_RDW: begin
                    if (lat_write) begin
                        state              <= S_WR;
                        bus.mem_write      <= 1'b1;
                        bus.mem_write_data <= merged_word;
                    end else begin
                        state          <= S_DONE;
                        bus.resp_rdata <= load_data;
                        bus.resp_valid <= 1'b1;
                    end
                end
                S_WR: begin
                    state          <= S_DONE;
                    bus.mem_write  <= 1'b0;
                    bus.resp_valid <= 1'b1;
                end
                S_DONE, S_ERR: begin
                    state          <= S_IDLE;
                    bus.resp_valid <= 1'b0;
                    bus.resp_error <= 1'b0;
                    bus.req_ready  <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed requests, a byte-level
// reference model with its own memory image, and a per-cycle response checker.
module tb_load_store_unit;
    import mips_mem_pkg::*;

    localparam bit BE = 1'b1;

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        logic        err;
        logic        st;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    load_store_unit_if #(.ADDR_W(32), .DATA_W(32)) bus();

    load_store_unit #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .BIG_ENDIAN (BE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] mem     [0:63];
    logic [31:0] ref_mem [0:63];
    exp_t        exp_q[$];
    int          cyc       = 0;
    int          n_checks  = 0;
    int          n_errors  = 0;
    int          wr_count  = 0;
    int          acc_count = 0;
    logic [31:0] last_rdata = '0;
    logic        last_err   = 1'b0;
    bit          exp_valid;
    int          acc_a;
    int          acc_b;

    always #5 clk = ~clk;

    // Cycle index: the value seen during the interval following each rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Data memory: synchronous read, write on mem_write.
    always @(posedge clk) begin
        bus.mem_read_data <= mem[bus.mem_address[7:2]];
        if (bus.mem_write) mem[bus.mem_address[7:2]] = bus.mem_write_data;
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic void split(input logic [31:0] w, output logic [7:0] b [4]);
        for (int n = 0; n < 4; n++) b[n] = BE ? w[31-8*n -: 8] : w[8*n +: 8];
    endfunction

    function automatic logic [31:0] join_bytes(input logic [7:0] b [4]);
        logic [31:0] w;
        w = '0;
        for (int n = 0; n < 4; n++) begin
            if (BE) w[31-8*n -: 8] = b[n];
            else    w[8*n +: 8]    = b[n];
        end
        return w;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] w, input int off,
                                               input logic [1:0] size, input logic sgn);
        logic [7:0] b [4];
        int v;
        split(w, b);
        if (size == SZ_BYTE) begin
            v = int'(b[off]);
            if (sgn && v >= 128) v = v - 256;
            return 32'(v);
        end else if (size == SZ_HALF) begin
            v = BE ? int'(b[off]) * 256 + int'(b[off+1]) : int'(b[off+1]) * 256 + int'(b[off]);
            if (sgn && v >= 32768) v = v - 65536;
            return 32'(v);
        end
        return w;
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] w, input int off,
                                                input logic [1:0] size, input logic [31:0] d);
        logic [7:0] b [4];
        if (size == SZ_WORD) return d;
        split(w, b);
        if (size == SZ_BYTE) begin
            b[off] = d[7:0];
        end else if (BE) begin
            b[off]   = d[15:8];
            b[off+1] = d[7:0];
        end else begin
            b[off]   = d[7:0];
            b[off+1] = d[15:8];
        end
        return join_bytes(b);
    endfunction

    function automatic logic model_err(input logic [31:0] addr, input logic [1:0] size);
        return (size == SZ_RSVD) || (size == SZ_HALF && addr[0]) ||
               (size == SZ_WORD && addr[1:0] != 2'b00);
    endfunction

    // Compare process: resp_valid every cycle, payload on response cycles; stores commit to the model on response.
    always @(negedge clk) begin
        if (!reset) begin
            exp_valid = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
            check_output("resp_valid", 32'(bus.resp_valid), 32'(exp_valid));
            if (exp_valid) begin
                check_output("resp_rdata", bus.resp_rdata, exp_q[0].rdata);
                check_output("resp_error", 32'(bus.resp_error), 32'(exp_q[0].err));
            end
            if (bus.resp_valid) begin
                last_rdata = bus.resp_rdata;
                last_err   = bus.resp_error;
            end
            if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                if (exp_q[0].st && !exp_q[0].err)
                    ref_mem[exp_q[0].addr[7:2]] = model_store(ref_mem[exp_q[0].addr[7:2]],
                        int'(exp_q[0].addr[1:0]), exp_q[0].size, exp_q[0].wdata);
                void'(exp_q.pop_front());
            end
            if (bus.mem_write) begin
                wr_count++;
                check_output("mem_address low bits", 32'(bus.mem_address[1:0]), 32'd0);
            end
            if (bus.req_valid && bus.req_ready) acc_count++;
        end
    end

    task automatic preload(input logic [31:0] addr, input logic [31:0] w);
        mem[addr[7:2]]     = w;
        ref_mem[addr[7:2]] = w;
    endtask

    task automatic apply_stimulus(input logic wr, input logic [1:0] size, input logic sgn,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  input bit hold, output int acc);
        exp_t e;
        bit   ok;
        int   lat;
        bus.req_valid  = 1'b1;
        bus.req_write  = wr;
        bus.req_size   = size;
        bus.req_signed = sgn;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check_output("req_ready timeout", 32'd0, 32'd1);
            bus.req_valid = 1'b0;
            acc = -1;
            return;
        end
        @(posedge clk);
        #1;
        acc = cyc;
        if (!hold) bus.req_valid = 1'b0;
        e.err   = model_err(addr, size);
        e.st    = wr;
        e.addr  = addr;
        e.wdata = wdata;
        e.size  = size;
        e.rdata = '0;
        if (e.err)           lat = 1;
        else if (!wr)        lat = 3;
        else if (size == SZ_WORD) lat = 2;
        else                 lat = 4;
        if (!e.err && !wr) e.rdata = model_load(ref_mem[addr[7:2]], int'(addr[1:0]), size, sgn);
        e.cyc = acc + lat - 1;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            check_output("response timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global timeout: errors=%0d checks=%0d", n_errors, n_checks);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        for (int i = 0; i < 64; i++) preload(32'(i * 4), 32'h0);
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_size   = SZ_BYTE;
        bus.req_signed = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;

        repeat (2) @(posedge clk);
        #1;
        check_output("reset req_ready", 32'(bus.req_ready), 32'd1);
        check_output("reset resp_valid", 32'(bus.resp_valid), 32'd0);
        check_output("reset resp_rdata", bus.resp_rdata, 32'd0);
        check_output("reset resp_error", 32'(bus.resp_error), 32'd0);
        check_output("reset mem_write", 32'(bus.mem_write), 32'd0);
        check_output("reset mem_address", bus.mem_address, 32'd0);
        check_output("reset mem_write_data", bus.mem_write_data, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Word store then word load.
        apply_stimulus(1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, acc_a);
        wait_idle();
        check_output("sw memory", mem[4], 32'hDEADBEEF);
        apply_stimulus(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 1'b0, acc_a);
        wait_idle();
        check_output("lw data", last_rdata, 32'hDEADBEEF);

        // Lane extraction and extension.
        preload(32'h20, 32'h80FF7F01);
        apply_stimulus(1'b0, SZ_BYTE, 1'b1, 32'h20, 32'h0, 1'b0, acc_a);
        wait_idle();
        check_output("lb @20", last_rdata, 32'hFFFFFF80);
        apply_stimulus(1'b0, SZ_BYTE, 1'b0, 32'h21, 32'h0, 1'b0, acc_a);
        wait_idle();
        check_output("lbu @21", last_rdata, 32'h000000FF);
        apply_stimulus(1'b0, SZ_HALF, 1'b1, 32'h22, 32'h0, 1'b0, acc_a);
        wait_idle();
        check_output("lh @22", last_rdata, 32'h00007F01);
        apply_stimulus(1'b0, SZ_HALF, 1'b0, 32'h20, 32'h0, 1'b0, acc_a);
        wait_idle();
        check_output("lhu @20", last_rdata, 32'h000080FF);
        apply_stimulus(1'b0, SZ_HALF, 1'b1, 32'h20, 32'h0, 1'b0, acc_a);
        wait_idle();
        check_output("lh @20", last_rdata, 32'hFFFF80FF);

        // Sub-word stores (read-modify-write).
        preload(32'h20, 32'h11223344);
        wr_count = 0;
        apply_stimulus(1'b1, SZ_BYTE, 1'b0, 32'h23, 32'h000000AA, 1'b0, acc_a);
        wait_idle();
        check_output("sb memory", mem[8], 32'h112233AA);
        check_output("sb write cycles", 32'(wr_count), 32'd1);
        apply_stimulus(1'b1, SZ_HALF, 1'b0, 32'h20, 32'h1234CAFE, 1'b0, acc_a);
        wait_idle();
        check_output("sh memory", mem[8], 32'hCAFE33AA);
        check_output("sh model memory", mem[8], ref_mem[8]);

        // Error requests: no memory traffic, address bus left where the last access put it.
        apply_stimulus(1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, 1'b0, acc_a);
        wait_idle();
        wr_count = 0;
        apply_stimulus(1'b0, SZ_HALF, 1'b1, 32'h31, 32'h0, 1'b0, acc_a);
        wait_idle();
        check_output("lh misaligned error", 32'(last_err), 32'd1);
        apply_stimulus(1'b0, SZ_WORD, 1'b0, 32'h32, 32'h0, 1'b0, acc_a);
        wait_idle();
        check_output("lw misaligned error", 32'(last_err), 32'd1);
        apply_stimulus(1'b1, SZ_RSVD, 1'b0, 32'h34, 32'h5A5A5A5A, 1'b0, acc_a);
        wait_idle();
        check_output("reserved size error", 32'(last_err), 32'd1);
        check_output("reserved size rdata", last_rdata, 32'd0);
        check_output("error mem_write count", 32'(wr_count), 32'd0);
        check_output("error mem_address", bus.mem_address, 32'h20);
        check_output("error memory untouched", mem[13], 32'h0);

        // Reset during the read phase of a sub-word store aborts it.
        preload(32'h40, 32'h55555555);
        apply_stimulus(1'b1, SZ_BYTE, 1'b0, 32'h40, 32'h000000AA, 1'b0, acc_a);
        @(negedge clk);
        @(negedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        #1;
        check_output("abort req_ready", 32'(bus.req_ready), 32'd1);
        check_output("abort mem_write", 32'(bus.mem_write), 32'd0);
        check_output("abort resp_valid", 32'(bus.resp_valid), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_output("abort memory", mem[16], 32'h55555555);

        // Held req_valid: second request accepted the cycle after the first response.
        acc_count = 0;
        apply_stimulus(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 1'b1, acc_a);
        apply_stimulus(1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, 1'b0, acc_b);
        wait_idle();
        check_output("held accept cycle", 32'(acc_b), 32'(acc_a + 4));
        check_output("held accept count", 32'(acc_count), 32'd2);

        // Store then load to the same word, back to back.
        apply_stimulus(1'b1, SZ_WORD, 1'b0, 32'h50, 32'h12345678, 1'b1, acc_a);
        apply_stimulus(1'b0, SZ_WORD, 1'b0, 32'h50, 32'h0, 1'b0, acc_b);
        wait_idle();
        check_output("store-load forward", last_rdata, 32'h12345678);
        check_output("store-load accept cycle", 32'(acc_b), 32'(acc_a + 3));

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the CPU datapath and the word-addressed data memory.
- Accepts one byte, halfword or word load/store request at a time over a valid/ready handshake.
- Translates each request into whole-word memory accesses. Sub-word stores become a read-modify-write sequence.
- Returns aligned, sign- or zero-extended load data with a one-cycle response pulse, and flags misaligned accesses.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, word width; only 32 supported.
- BIG_ENDIAN, 1, 1 = byte offset 0 maps to bits [31:24] (MIPS); 0 = byte offset 0 maps to bits [7:0].

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit idle; request accepted on clk edge when req_valid & req_ready
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_signed  in  1  sign-extend load result (byte/half only)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data (0 for stores/errors)
- resp_error  out  1  valid with resp_valid; misaligned or reserved size
- mem_address  out  32  byte address to memory, low 2 bits forced 0
- mem_write  out  1  memory write enable
- mem_write_data  out  32  full word to write
- mem_read_data  in  32  memory read word, valid the cycle after mem_address is presented with mem_write=0

Behaviour:
- Reset (async): state = IDLE. Outputs: req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0, mem_write=0, mem_address=0, mem_write_data=0.
- Request latching: on acceptance, latch write, size, signed, addr and wdata. req_valid while req_ready=0 is ignored; the requester holds it.
- Memory-side outputs are decoded from state and latched registers only; they never depend combinationally on req_*.
- States:
  - IDLE: req_ready=1.
    - Accept + (misaligned or size 11) -> ERR.
    - Accept + word store -> WR.
    - Accept + other -> RD.
    - Misaligned: half with addr[0]=1; word with addr[1:0]!=0.
  - RD: mem_address=word addr, mem_write=0 -> RDW.
  - RDW: mem_read_data valid.
    - Load: extract lane, extend, register into resp_rdata -> DONE.
    - Sub-word store: merge wdata lane into read word, register merged word -> WR.
  - WR: mem_write=1, mem_address=word addr, mem_write_data = merged word (sub-word) or latched wdata (word) -> DONE.
  - ERR: resp_valid=1, resp_error=1, resp_rdata=0 -> IDLE. No memory access occurs.
  - DONE: resp_valid=1, resp_error=0 -> IDLE.
- Latency from the acceptance edge to the resp_valid cycle:
  - error: 1
  - word store: 2
  - load: 3
  - sub-word store: 4
- Throughput: a new request can be accepted the cycle after resp_valid (in IDLE).
- Lane extraction, big-endian: byte n = bits [31-8n : 24-8n]; half at offset 0 = [31:16], offset 2 = [15:0]. Little-endian mirrors this.
- Extension: byte/half zero-extended unless req_signed. req_signed is ignored for words.
- Merge: only the addressed lane is replaced; the other bytes come from the RDW read word.
- Reset mid-operation: asserting reset in RD/RDW/WR aborts the request; mem_write drops immediately. The memory is unchanged unless the WR edge had already occurred. No resp_valid is issued.
- Back-to-back: a store and then a load to the same word return the stored data (the store commits in WR before the load's RD).

Decomposition:
- Shared package mips_mem_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD
  - lsu state enum
  - function word_align(addr)
- Sub-module lsu_align (combinational):
  - inputs: offset, size, signed, endianness, read word, store data
  - outputs: extended load data, merged store word, misaligned flag

Test Plan:
- Word store 0xDEADBEEF @0x10, then word load @0x10 -> store resp_valid 2 cycles after accept; load resp_rdata=0xDEADBEEF 3 cycles after accept.
- Memory word 0x80FF7F01 @0x20, BIG_ENDIAN=1:
  - lb @0x20 -> 0xFFFFFF80
  - lbu @0x21 -> 0x000000FF
  - lh @0x22 -> 0x00007F01
  - lhu @0x20 -> 0x000080FF
- sb 0xAA @0x23 onto 0x11223344 -> memory 0x112233AA. resp_valid 4 cycles after accept, exactly one mem_write cycle.
- lh @0x31, lw @0x32, size 11 -> resp_error=1 one cycle after accept; mem_write never asserted; mem_address unchanged.
- Reset during RDW of a sb @0x40 (old 0x55555555) -> memory still 0x55555555, resp_valid never pulses, req_ready=1 immediately.
- req_valid held high while busy -> only one acceptance per req_ready cycle; the second request is accepted the cycle after resp_valid.
